// File: rtl/draw_canvas_if.sv
// draw_canvas_if: row-major dump stream from the canvas to the classifier.
// master = canvas (producer), slave = classifier (consumer).
interface draw_canvas_if #(
  parameter int PIX_BITS = 1
);
  logic                dump_valid;
  logic                dump_last;
  logic [PIX_BITS-1:0] dump_data;
  logic                dump_ready;

  modport master (
    output dump_valid,
    output dump_last,
    output dump_data,
    input  dump_ready
  );

  modport slave (
    input  dump_valid,
    input  dump_last,
    input  dump_data,
    output dump_ready
  );
endinterface

// File: rtl/draw_canvas.sv
// draw_canvas: cell canvas with rate-limited cursor, pen, VGA read port, dump stream.
// Define CANVAS_SOFT_BRUSH_EN to add the soft-brush BRUSH state.
module draw_canvas #(
  parameter int GRID_W     = 28,
  parameter int GRID_H     = 28,
  parameter int PIX_BITS   = 1,
  parameter int MOVE_DELAY = 1000000,
  parameter int XW         = $clog2(GRID_W),
  parameter int YW         = $clog2(GRID_H)
) (
  input  logic                CLOCK_50,
  input  logic                reset,
  input  logic                btn_down,
  input  logic                btn_up,
  input  logic                btn_right,
  input  logic                btn_left,
  input  logic                pen_en,
  input  logic                erase,
  input  logic                clear_req,
  input  logic                dump_start,
  input  logic [XW-1:0]       rd_x,
  input  logic [YW-1:0]       rd_y,
  output logic [PIX_BITS-1:0] rd_pix,
  output logic [XW-1:0]       cursor_x,
  output logic [YW-1:0]       cursor_y,
  output logic                busy,
  draw_canvas_if.master       dump
);

  localparam int N  = GRID_W * GRID_H;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = (MOVE_DELAY > 0) ? $clog2(MOVE_DELAY + 1) : 1;
  localparam logic [PIX_BITS-1:0] MAX   = '1;
  localparam logic [IW-1:0]       LAST  = IW'(N - 1);
  localparam logic [CW-1:0]       DELAY = CW'(MOVE_DELAY);

`ifdef CANVAS_SOFT_BRUSH_EN
  localparam logic [PIX_BITS-1:0] HALF = MAX >> 1;
  typedef enum logic [1:0] {IDLE, CLEAR, DUMP, BRUSH} state_t;
`else
  typedef enum logic [1:0] {IDLE, CLEAR, DUMP} state_t;
`endif

  function automatic logic [IW-1:0] addr_of(
    input logic [XW-1:0] x,
    input logic [YW-1:0] y
  );
    return IW'(32'(y) * GRID_W + 32'(x));
  endfunction

  logic [PIX_BITS-1:0] mem_q [N];

  state_t              state_q, state_d;
  logic [IW-1:0]       idx_q, idx_d, nxt_idx;
  logic [XW-1:0]       cur_x_q, cur_x_d;
  logic [YW-1:0]       cur_y_q, cur_y_d;
  logic [CW-1:0]       cool_q, cool_d;
  logic                busy_q, busy_d;
  logic                dump_valid_q, dump_valid_d;
  logic                dump_last_q, dump_last_d;
  logic [PIX_BITS-1:0] dump_data_q, dump_data_d;
  logic [PIX_BITS-1:0] rd_pix_q, rd_pix_d;

  logic                wr_en;
  logic [IW-1:0]       wr_addr;
  logic [PIX_BITS-1:0] wr_data;

`ifdef CANVAS_SOFT_BRUSH_EN
  logic [XW-1:0]       bx_q, bx_d, nb_x;
  logic [YW-1:0]       by_q, by_d, nb_y;
  logic [2:0]          step_q, step_d;
  logic                nb_ok;
  logic [IW-1:0]       nb_addr;
  logic [PIX_BITS-1:0] nb_old;
`endif

  // Registered VGA read; reads see the cell before this cycle's write.
  always_comb begin
    rd_pix_d = '0;
    if (32'(rd_x) < GRID_W && 32'(rd_y) < GRID_H)
      rd_pix_d = mem_q[addr_of(rd_x, rd_y)];
  end

  // Cursor: cooldown gate, then down>up>right>left, skipping blocked moves.
  always_comb begin
    cur_x_d = cur_x_q;
    cur_y_d = cur_y_q;
    cool_d  = cool_q;
    if (cool_q != '0) begin
      cool_d = cool_q - 1'b1;
    end else if (btn_down && 32'(cur_y_q) < GRID_H - 1) begin
      cur_y_d = cur_y_q + 1'b1;
      cool_d  = DELAY;
    end else if (btn_up && cur_y_q != '0) begin
      cur_y_d = cur_y_q - 1'b1;
      cool_d  = DELAY;
    end else if (btn_right && 32'(cur_x_q) < GRID_W - 1) begin
      cur_x_d = cur_x_q + 1'b1;
      cool_d  = DELAY;
    end else if (btn_left && cur_x_q != '0) begin
      cur_x_d = cur_x_q - 1'b1;
      cool_d  = DELAY;
    end
  end

  // Sequencer: clear sweep, dump stream, pen writes and optional brush.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    nxt_idx      = idx_q + 1'b1;
    dump_valid_d = dump_valid_q;
    dump_last_d  = dump_last_q;
    dump_data_d  = dump_data_q;
    wr_en        = 1'b0;
    wr_addr      = addr_of(cur_x_q, cur_y_q);
    wr_data      = '0;
`ifdef CANVAS_SOFT_BRUSH_EN
    bx_d    = bx_q;
    by_d    = by_q;
    step_d  = step_q;
    nb_ok   = 1'b0;
    nb_x    = bx_q;
    nb_y    = by_q;
    nb_addr = '0;
    nb_old  = '0;
`endif
    case (state_q)
      CLEAR: begin
        wr_en   = 1'b1;
        wr_addr = idx_q;
        if (idx_q == LAST) state_d = IDLE;
        else idx_d = nxt_idx;
      end
      DUMP: begin
        if (dump_valid_q && dump.dump_ready) begin
          if (idx_q == LAST) begin
            state_d      = IDLE;
            dump_valid_d = 1'b0;
            dump_last_d  = 1'b0;
            dump_data_d  = '0;
          end else begin
            idx_d       = nxt_idx;
            dump_data_d = mem_q[nxt_idx];
            dump_last_d = (nxt_idx == LAST);
          end
        end
      end
`ifdef CANVAS_SOFT_BRUSH_EN
      BRUSH: begin
        unique case (step_q)
          3'd0: begin
            nb_ok = (by_q != '0);
            nb_y  = by_q - 1'b1;
          end
          3'd1: begin
            nb_ok = (32'(by_q) < GRID_H - 1);
            nb_y  = by_q + 1'b1;
          end
          3'd2: begin
            nb_ok = (bx_q != '0);
            nb_x  = bx_q - 1'b1;
          end
          3'd3: begin
            nb_ok = (32'(bx_q) < GRID_W - 1);
            nb_x  = bx_q + 1'b1;
          end
          default: nb_ok = 1'b0;
        endcase
        nb_addr = addr_of(nb_x, nb_y);
        nb_old  = mem_q[nb_addr];
        wr_en   = nb_ok;
        wr_addr = nb_addr;
        wr_data = (nb_old > HALF) ? nb_old : HALF;
        // Step 4 is a closing cycle so a stroke always holds busy for 5 cycles.
        if (step_q == 3'd4) state_d = IDLE;
        else step_d = step_q + 1'b1;
      end
`endif
      default: begin
        if (clear_req) begin
          state_d = CLEAR;
          idx_d   = '0;
        end else if (dump_start) begin
          state_d      = DUMP;
          idx_d        = '0;
          dump_valid_d = 1'b1;
          dump_data_d  = mem_q[0];
          dump_last_d  = (LAST == '0);
        end else if (pen_en) begin
          wr_en   = 1'b1;
          wr_data = erase ? '0 : MAX;
`ifdef CANVAS_SOFT_BRUSH_EN
          if (!erase) begin
            state_d = BRUSH;
            bx_d    = cur_x_q;
            by_d    = cur_y_q;
            step_d  = '0;
          end
`endif
        end
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // Cell storage has no reset; CLEAR is the only way to zero it.
  always_ff @(posedge CLOCK_50) begin
    if (wr_en) mem_q[wr_addr] <= wr_data;
  end

  // State, cursor and registered outputs.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_q      <= CLEAR;
      idx_q        <= '0;
      cur_x_q      <= XW'(GRID_W / 2);
      cur_y_q      <= YW'(GRID_H / 2);
      cool_q       <= '0;
      busy_q       <= 1'b1;
      dump_valid_q <= 1'b0;
      dump_last_q  <= 1'b0;
      dump_data_q  <= '0;
      rd_pix_q     <= '0;
`ifdef CANVAS_SOFT_BRUSH_EN
      bx_q         <= '0;
      by_q         <= '0;
      step_q       <= '0;
`endif
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cur_x_q      <= cur_x_d;
      cur_y_q      <= cur_y_d;
      cool_q       <= cool_d;
      busy_q       <= busy_d;
      dump_valid_q <= dump_valid_d;
      dump_last_q  <= dump_last_d;
      dump_data_q  <= dump_data_d;
      rd_pix_q     <= rd_pix_d;
`ifdef CANVAS_SOFT_BRUSH_EN
      bx_q         <= bx_d;
      by_q         <= by_d;
      step_q       <= step_d;
`endif
    end
  end

  assign rd_pix          = rd_pix_q;
  assign cursor_x        = cur_x_q;
  assign cursor_y        = cur_y_q;
  assign busy            = busy_q;
  assign dump.dump_valid = dump_valid_q;
  assign dump.dump_last  = dump_last_q;
  assign dump.dump_data  = dump_data_q;

endmodule

// File: doc/draw_canvas.md
# draw_canvas

Parametrised drawing canvas that stores a GRID_W×GRID_H image of PIX_BITS-deep cells, moves a cursor under rate-limited button control, and paints or erases cells at the cursor. It serves the VGA renderer through a registered random-access read port and streams the finished image, row-major, to the downstream classifier over a valid/ready interface. A sequencer also clears the canvas on request and after reset.

## Interface
- GRID_W, 28, canvas width in cells
- GRID_H, 28, canvas height in cells
- PIX_BITS, 1, bits per cell; full ink MAX = 2^PIX_BITS−1
- MOVE_DELAY, 1000000, cooldown in cycles after each cursor step
- XW/YW, $clog2(GRID_W)/$clog2(GRID_H), coordinate widths (derived)

Ports:
- CLOCK_50  in  1  sole clock; all logic on rising edge
- reset  in  1  asynchronous, active-high reset
- btn_down, btn_up, btn_right, btn_left  in  1 each  active-high, already synchronised
- pen_en  in  1  paint at cursor while high
- erase  in  1  with pen_en: write 0 instead of ink
- clear_req  in  1  pulse: zero the whole canvas
- dump_start  in  1  pulse: stream canvas out
- rd_x / rd_y  in  XW / YW  VGA read coordinates
- rd_pix  out  PIX_BITS  cell at (rd_x,rd_y), one cycle later
- cursor_x / cursor_y  out  XW / YW  current cursor
- busy  out  1  high in any state other than IDLE
- dump_valid, dump_last  out  1 each  stream qualifiers
- dump_data  out  PIX_BITS  stream payload
- dump_ready  in  1  downstream accept

## Operation
- Storage: register array, address = y*GRID_W + x; not reset, only cleared by the CLEAR state.
- FSM states: IDLE, CLEAR, DUMP, BRUSH (BRUSH exists only with the macro).
- Reset: FSM→CLEAR, clear index 0, cursor (GRID_W/2, GRID_H/2), cooldown 0, busy 1, dump_valid/dump_last/dump_data/rd_pix 0.
- CLEAR: one cell zeroed per cycle, index 0..GRID_W*GRID_H−1, then IDLE. Duration GRID_W*GRID_H cycles.
- IDLE: clear_req→CLEAR; else dump_start→DUMP; else pen_en paints the cursor cell (erase? 0 : MAX) every cycle it is held. clear_req beats dump_start in the same cycle. clear_req/dump_start are ignored outside IDLE.
- DUMP: index 0 on entry; dump_valid=1, dump_data=cell[index], dump_last=(index==last). Index advances only on dump_valid&&dump_ready. Handshake on the last cell → IDLE with dump_valid=0 the next cycle. dump_data is held stable while dump_valid&&!dump_ready. Pen writes are suppressed.
- Cursor: runs in every state. Cooldown counts down to 0. When it is 0, priority is down>up>right>left; the first held button whose move stays in the grid steps by 1 and loads MOVE_DELAY. A blocked move at an edge neither steps nor loads cooldown, and lower-priority buttons are then evaluated.
- Read port: rd_pix registered. An out-of-range rd_x/rd_y returns 0.

## Timing
- rd_pix latency: 1 cycle. A write and a read to the same cell in the same cycle return the old value.
- Cursor step is visible on cursor_x/y the cycle after the button is sampled with cooldown 0. The next step is possible MOVE_DELAY+1 cycles later.
- dump_valid rises the cycle after dump_start is accepted. Maximum throughput is 1 cell/cycle.
- busy rises the cycle after an accepted request and falls the cycle after the terminal action.
- Reset asserted mid-CLEAR/DUMP/BRUSH aborts at once. The stream drops without dump_last, and a full CLEAR reruns.

## Configuration
- CANVAS_SOFT_BRUSH_EN defined: a pen stroke in IDLE (not erase) writes MAX to the center cell, latches the cursor, and enters BRUSH.
  - BRUSH spends 4 cycles on neighbours N, S, W, E in that order.
  - Each neighbour is written with max(existing, MAX>>1). An off-grid neighbour is skipped, but its cycle is still consumed.
  - BRUSH then returns to IDLE. Requests arriving in BRUSH are ignored, and a held pen retriggers the stroke.
- Undefined: no BRUSH state; the center cell only; busy never rises for painting.

## Test plan
- Reset, release → busy=1 for exactly 784 cycles. Then every rd_pix=0, cursor=(14,14), dump_valid=0.
- Hold btn_down with MOVE_DELAY=4 from y=26 → y=27 after 1 cycle. Hold 20 more cycles → y stays 27 and cooldown is not reloaded. Press btn_down and btn_right together at y=27 → x increments.
- pen_en at (3,5), PIX_BITS=2 → rd_x=3, rd_y=5 gives rd_pix=3 next cycle. erase+pen_en → 0.
- dump_start with dump_ready toggling 1,0,0,1,… → 784 beats in row-major order, with data held across stalls. dump_last only on beat 784, and busy falls the cycle after.
- clear_req and dump_start in the same cycle → CLEAR runs and no dump_valid appears. Reset at DUMP beat 100 → dump_valid=0 immediately and CLEAR reruns.
- CANVAS_SOFT_BRUSH_EN, PIX_BITS=2, pen pulse at (0,0) → (0,0)=3, (0,1)=1, (1,0)=1. busy lasts exactly 5 cycles, and a previously inked neighbour at 3 stays 3.
